// File: rtl/wc_pin_bridge.sv
// wc_pin_bridge: pin-side bridge for a Winograd filter core.
// Collects R coefficients and a tile of T = M+R-1 samples from a narrow pin
// bus, launches the core, and serialises the M core results back onto Z.
// Optional feature: define WC_OVERLAP_EN for overlap-save reuse of the last
// R-1 samples of each tile as the head of the next one.
module wc_pin_bridge #(
    parameter int PIN_W = 10,
    parameter int M     = 7,
    parameter int R     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PIN_W-1:0]             D,
    input  logic                         D_VLD,
    input  logic                         D_SEL,
    output logic [PIN_W-1:0]             Z,
    output logic                         Z_VLD,
    output logic                         BUSY,
    output logic [(M+R-1)*PIN_W-1:0]     tile_o,
    output logic [R*PIN_W-1:0]           coef_o,
    output logic                         core_start,
    input  logic                         core_done,
    input  logic [M*PIN_W-1:0]           core_res
);

    localparam int T      = M + R - 1;
    localparam int CIDX_W = (R > 1) ? $clog2(R) : 1;
    localparam int TIDX_W = $clog2(T + 1);
    localparam int DIDX_W = $clog2(M + 1);

    localparam logic [CIDX_W-1:0] CIDX_LAST = CIDX_W'(R - 1);
    localparam logic [TIDX_W-1:0] TIDX_LAST = TIDX_W'(T - 1);
    localparam logic [DIDX_W-1:0] DIDX_END  = DIDX_W'(M);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN
    } state_t;

    state_t            state;
    logic [CIDX_W-1:0] cidx;
    logic [TIDX_W-1:0] tidx;
    logic [DIDX_W-1:0] didx;
    logic [PIN_W-1:0]  tile   [T];
    logic [PIN_W-1:0]  coef   [R];
    logic [PIN_W-1:0]  result [M];

    // Tile and coefficient registers are exposed directly as flat buses.
    for (genvar k = 0; k < T; k++) begin : g_tile
        assign tile_o[k*PIN_W +: PIN_W] = tile[k];
    end

    for (genvar j = 0; j < R; j++) begin : g_coef
        assign coef_o[j*PIN_W +: PIN_W] = coef[j];
    end

    // Control FSM with registered outputs: load, launch core, drain results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cidx       <= '0;
            tidx       <= '0;
            didx       <= '0;
            Z          <= '0;
            Z_VLD      <= 1'b0;
            BUSY       <= 1'b0;
            core_start <= 1'b0;
            for (int unsigned k = 0; k < T; k++) tile[k]   <= '0;
            for (int unsigned j = 0; j < R; j++) coef[j]   <= '0;
            for (int unsigned i = 0; i < M; i++) result[i] <= '0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (D_VLD && D_SEL && state == IDLE) begin
                        coef[cidx] <= D;
                        cidx       <= (cidx == CIDX_LAST) ? '0 : cidx + 1'b1;
`ifdef WC_OVERLAP_EN
                        // New coefficients invalidate any retained overlap samples.
                        tidx       <= '0;
`endif
                    end else if (D_VLD && !D_SEL) begin
                        tile[tidx] <= D;
                        if (tidx == TIDX_LAST) begin
                            tidx       <= '0;
                            state      <= RUN;
                            core_start <= 1'b1;
                            BUSY       <= 1'b1;
                        end else begin
                            tidx  <= tidx + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                RUN: begin
                    if (core_done) begin
                        for (int unsigned i = 0; i < M; i++)
                            result[i] <= core_res[i*PIN_W +: PIN_W];
                        Z     <= core_res[PIN_W-1:0];
                        Z_VLD <= 1'b1;
                        didx  <= DIDX_W'(1);
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (didx == DIDX_END) begin
                        Z     <= '0;
                        Z_VLD <= 1'b0;
                        BUSY  <= 1'b0;
                        didx  <= '0;
                        state <= IDLE;
`ifdef WC_OVERLAP_EN
                        for (int unsigned j = 0; j + 1 < R; j++)
                            tile[j] <= tile[M+j];
                        tidx <= TIDX_W'(R - 1);
`else
                        tidx <= '0;
`endif
                    end else begin
                        Z    <= result[didx];
                        didx <= didx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wc_pin_bridge.sv
// Testbench for wc_pin_bridge: table-driven main flow plus hand-written
// sequences for overlap reuse, coefficient-triggered reload and mid-drain reset.
// Build with or without WC_OVERLAP_EN, matching the RTL build.
module tb_wc_pin_bridge;

    localparam int PW = 10;
    localparam int MM = 7;
    localparam int RR = 3;
    localparam int TT = MM + RR - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [PW-1:0]     D = '0;
    logic              D_VLD = 1'b0;
    logic              D_SEL = 1'b0;
    logic [PW-1:0]     Z;
    logic              Z_VLD;
    logic              BUSY;
    logic [TT*PW-1:0]  tile_o;
    logic [RR*PW-1:0]  coef_o;
    logic              core_start;
    logic              core_done = 1'b0;
    logic [MM*PW-1:0]  core_res = '0;

    int checks = 0;
    int errors = 0;

    wc_pin_bridge #(.PIN_W(PW), .M(MM), .R(RR)) dut (
        .clk(clk), .rst(rst), .D(D), .D_VLD(D_VLD), .D_SEL(D_SEL),
        .Z(Z), .Z_VLD(Z_VLD), .BUSY(BUSY), .tile_o(tile_o), .coef_o(coef_o),
        .core_start(core_start), .core_done(core_done), .core_res(core_res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          vld;
        logic          sel;
        logic [PW-1:0] d;
        logic          done;
        logic          ezv;
        logic [PW-1:0] ez;
        logic          ebusy;
        logic          ecs;
        logic          chk_tile;
        logic          chk_coef;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic vld, input logic sel, input logic [PW-1:0] d, input logic done);
        D_VLD     = vld;
        D_SEL     = sel;
        D         = d;
        core_done = done;
        @(posedge clk);
        #1;
        D_VLD     = 1'b0;
        D_SEL     = 1'b0;
        D         = '0;
        core_done = 1'b0;
    endtask

    task automatic add(input logic vld, input logic sel, input int d, input logic done,
                       input logic ezv, input int ez, input logic ebusy, input logic ecs,
                       input logic ct, input logic cc);
        vec_t v;
        v.vld = vld; v.sel = sel; v.d = PW'(d); v.done = done;
        v.ezv = ezv; v.ez = PW'(ez); v.ebusy = ebusy; v.ecs = ecs;
        v.chk_tile = ct; v.chk_coef = cc;
        vq.push_back(v);
    endtask

    function automatic logic [TT*PW-1:0] tile_seq(input int first);
        logic [TT*PW-1:0] t;
        t = '0;
        for (int k = 0; k < TT; k++) t[k*PW +: PW] = PW'(first + k);
        return t;
    endfunction

    task automatic set_res(input int first);
        for (int i = 0; i < MM; i++) core_res[i*PW +: PW] = PW'(first + i);
    endtask

    task automatic drain_check(input int first, input string tag);
        for (int i = 1; i < MM; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            chk({tag, "_zv"}, Z_VLD, 1'b1);
            chk({tag, "_z"}, Z, PW'(first + i));
        end
        step(1'b0, 1'b0, '0, 1'b0);
        chk({tag, "_end_zv"}, Z_VLD, 1'b0);
        chk({tag, "_end_z"}, Z, '0);
        chk({tag, "_end_busy"}, BUSY, 1'b0);
    endtask

    logic [TT*PW-1:0] tile_ref;
    logic [RR*PW-1:0] coef_ref;

    initial begin
        // Main-flow vector table: each row is one clock with expected outputs after the edge.
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 9, 0, 0, 0, 0, 0, 0, 1);                 // 4th word wraps to coef[0]
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);                 // core_done in IDLE ignored
        for (int s = 1; s <= 8; s++) add(1, 0, s, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 9, 0, 0, 0, 1, 1, 1, 0);                 // 9th sample -> RUN, core_start
        add(1, 0, 99, 0, 0, 0, 1, 0, 1, 0);                // sample in RUN ignored
        add(1, 1, 77, 0, 0, 0, 1, 0, 1, 1);                // coef in RUN ignored
        add(0, 0, 0, 1, 1, 10, 1, 0, 1, 0);                // core_done -> Z=10 next cycle
        add(1, 0, 55, 0, 1, 11, 1, 0, 0, 0);               // sample in DRAIN ignored
        add(0, 0, 0, 1, 1, 12, 1, 0, 0, 0);                // core_done in DRAIN ignored
        for (int z = 13; z <= 16; z++) add(0, 0, 0, 0, 1, z, 1, 0, z == 16, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);                 // back to IDLE

        tile_ref = tile_seq(1);
        coef_ref = '0;
        coef_ref[0*PW +: PW] = PW'(9);
        coef_ref[1*PW +: PW] = PW'(2);
        coef_ref[2*PW +: PW] = PW'(3);
        set_res(10);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_zv", Z_VLD, 1'b0);
        chk("rst_z", Z, '0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_cs", core_start, 1'b0);
        chk("rst_tile", tile_o, '0);
        chk("rst_coef", coef_o, '0);

        foreach (vq[r]) begin
            step(vq[r].vld, vq[r].sel, vq[r].d, vq[r].done);
            chk($sformatf("row%0d_zv", r), Z_VLD, vq[r].ezv);
            chk($sformatf("row%0d_z", r), Z, vq[r].ez);
            chk($sformatf("row%0d_busy", r), BUSY, vq[r].ebusy);
            chk($sformatf("row%0d_cs", r), core_start, vq[r].ecs);
            if (vq[r].chk_tile) chk($sformatf("row%0d_tile", r), tile_o, tile_ref);
            if (vq[r].chk_coef) chk($sformatf("row%0d_coef", r), coef_o, coef_ref);
        end

        // Second tile: overlap build reuses 8,9 and needs only 7 new samples.
        set_res(20);
`ifdef WC_OVERLAP_EN
        for (int i = 0; i < MM; i++) begin
            step(1'b1, 1'b0, PW'(10 + i), 1'b0);
            chk($sformatf("ovl_cs%0d", i), core_start, i == MM - 1);
            chk($sformatf("ovl_busy%0d", i), BUSY, i == MM - 1);
        end
        tile_ref = tile_seq(8);
`else
        for (int i = 0; i < TT; i++) begin
            step(1'b1, 1'b0, PW'(10 + i), 1'b0);
            chk($sformatf("t2_cs%0d", i), core_start, i == TT - 1);
            chk($sformatf("t2_busy%0d", i), BUSY, i == TT - 1);
        end
        tile_ref = tile_seq(10);
`endif
        chk("t2_tile", tile_o, tile_ref);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("t2_z0v", Z_VLD, 1'b1);
        chk("t2_z0", Z, PW'(20));
        drain_check(20, "t2");

        // Coefficient write clears any overlap: next tile needs all samples.
        step(1'b1, 1'b1, PW'(5), 1'b0);
        coef_ref[1*PW +: PW] = PW'(5);
        chk("cw_coef", coef_o, coef_ref);
        chk("cw_busy", BUSY, 1'b0);
        for (int i = 0; i < TT; i++) begin
            step(1'b1, 1'b0, PW'(30 + i), 1'b0);
            chk($sformatf("t3_cs%0d", i), core_start, i == TT - 1);
        end
        chk("t3_tile", tile_o, tile_seq(30));

        // Reset during DRAIN cycle 3 aborts the drain.
        step(1'b0, 1'b0, '0, 1'b1);
        chk("t3_z0", Z, PW'(20));
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t3_z1", Z, PW'(21));
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t3_z2", Z, PW'(22));
        rst = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        chk("ar_zv", Z_VLD, 1'b0);
        chk("ar_z", Z, '0);
        chk("ar_busy", BUSY, 1'b0);
        chk("ar_cs", core_start, 1'b0);
        chk("ar_tile", tile_o, '0);
        chk("ar_coef", coef_o, '0);
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ar_idle_zv%0d", i), Z_VLD, 1'b0);
            step(1'b0, 1'b0, '0, 1'b0);
        end
        for (int i = 0; i < TT; i++) begin
            step(1'b1, 1'b0, PW'(40 + i), 1'b0);
            chk($sformatf("t4_cs%0d", i), core_start, i == TT - 1);
        end
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t4_cs_pulse", core_start, 1'b0);
        chk("t4_busy", BUSY, 1'b1);
        chk("t4_tile", tile_o, tile_seq(40));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
